// File: rtl/regwb_pkg.sv
// regwb_pkg: shared widths, the XZR address and the queued-result record for the writeback sequencer.
package regwb_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int XZR_ADDR   = 31;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] add;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry circular buffer; with WB_BYPASS_EN it also exposes all entries oldest-first.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 69
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
`ifdef WB_BYPASS_EN
    output logic [DEPTH*W-1:0]        o_view,
    output logic [DEPTH-1:0]          o_vld,
`endif
    input  logic                      i_push,
    input  logic [W-1:0]              i_din,
    input  logic                      i_pop,
    output logic [W-1:0]              o_dout,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    // Storage needs no reset: entries are only visible below r_count.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end
    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;
`ifdef WB_BYPASS_EN
    for (genvar k = 0; k < DEPTH; k++) begin : g_view
        assign o_view[k*W +: W] = r_mem[r_rd + AW'(k)];
        assign o_vld[k]         = (AW+1)'(k) < r_count;
    end
`endif
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: queues ALU/load results and drives the register file write port one write per cycle.
// Define WB_BYPASS_EN to add the fwd_* lookup of queued and in-flight writes.
module regfile_writeback
    import regwb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_add,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_add,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              hold,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_add,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] fwd_add1,
    input  logic [ADDR_W-1:0] fwd_add2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_ADDR);
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_mem_fire;
    logic              w_alu_fire;
    logic              w_push;
    logic              w_pop;
    logic [EW-1:0]     w_din;
    logic [EW-1:0]     w_dout;
    logic              r_we;
    logic [ADDR_W-1:0] r_add;
    logic [DATA_W-1:0] r_data;
`ifdef WB_BYPASS_EN
    logic [DEPTH*EW-1:0] w_view;
    logic [DEPTH-1:0]    w_vld;
`endif
    // Loads belong to older instructions, so mem wins when both offer.
    assign w_full     = w_count == CW'(DEPTH);
    assign mem_ready  = !w_full;
    assign alu_ready  = !w_full && !mem_valid;
    assign w_mem_fire = mem_valid && mem_ready;
    assign w_alu_fire = alu_valid && alu_ready;
    assign w_push     = (w_mem_fire && mem_add != XZR) || (w_alu_fire && alu_add != XZR);
    assign w_din      = w_mem_fire ? {mem_add, mem_data} : {alu_add, alu_data};
    assign w_pop      = !hold && w_count != '0;
    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
`ifdef WB_BYPASS_EN
        .o_view  (w_view),
        .o_vld   (w_vld),
`endif
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_count (w_count)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_add  <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_pop;
            if (w_pop) {r_add, r_data} <= w_dout;
        end
    end
    assign write_en   = r_we;
    assign write_add  = r_add;
    assign write_data = r_data;
    assign busy       = w_count != '0 || r_we;
`ifdef WB_BYPASS_EN
    // Output register is oldest; later queue entries (younger) override it.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a,
                                               input logic [DEPTH*EW-1:0] view,
                                               input logic [DEPTH-1:0] vld,
                                               input logic we,
                                               input logic [ADDR_W-1:0] wadd,
                                               input logic [DATA_W-1:0] wdata);
        logic [DATA_W:0] r;
        r = (we && wadd == a) ? {1'b1, wdata} : '0;
        for (int k = 0; k < DEPTH; k++)
            if (vld[k] && view[k*EW+DATA_W +: ADDR_W] == a) r = {1'b1, view[k*EW +: DATA_W]};
        if (a == XZR) r = '0;
        return r;
    endfunction
    always_comb begin
        {fwd_hit1, fwd_data1} = lookup(fwd_add1, w_view, w_vld, r_we, r_add, r_data);
        {fwd_hit2, fwd_data2} = lookup(fwd_add2, w_view, w_vld, r_we, r_add, r_data);
    end
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vector table plus hand sequences for bypass and mid-run reset.
module tb_regfile_writeback;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, hold = 1'b0;
    logic [4:0]  alu_add = '0, mem_add = '0;
    logic [63:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, write_en, busy;
    logic [4:0]  write_add;
    logic [63:0] write_data;
`ifdef WB_BYPASS_EN
    logic [4:0]  fwd_add1 = '0, fwd_add2 = '0;
    logic        fwd_hit1, fwd_hit2;
    logic [63:0] fwd_data1, fwd_data2;
`endif
    int checks = 0;
    int failures = 0;

    regfile_writeback dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_add(alu_add), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_add(mem_add), .mem_data(mem_data),
        .hold(hold), .write_en(write_en), .write_add(write_add), .write_data(write_data),
        .busy(busy)
`ifdef WB_BYPASS_EN
        , .fwd_add1(fwd_add1), .fwd_add2(fwd_add2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic mv; logic [4:0] madd; logic [63:0] mdata;
        logic av; logic [4:0] aadd; logic [63:0] adata;
        logic hold;
        logic e_ar; logic e_mr;
        logic e_we; logic [4:0] e_add; logic [63:0] e_data; logic e_busy;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t v(logic mv, logic [4:0] madd, logic [63:0] mdata,
                               logic av, logic [4:0] aadd, logic [63:0] adata, logic h,
                               logic ar, logic mr, logic we, logic [4:0] wa, logic [63:0] wd, logic b);
        vec_t r;
        r.mv = mv; r.madd = madd; r.mdata = mdata;
        r.av = av; r.aadd = aadd; r.adata = adata; r.hold = h;
        r.e_ar = ar; r.e_mr = mr; r.e_we = we; r.e_add = wa; r.e_data = wd; r.e_busy = b;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; mem_valid = 1'b0;
    endtask

    task automatic check_out(string tag, logic we, logic [4:0] wa, logic [63:0] wd, logic b);
        check({tag, ".write_en"}, 64'(write_en), 64'(we));
        check({tag, ".write_add"}, 64'(write_add), 64'(wa));
        check({tag, ".write_data"}, write_data, wd);
        check({tag, ".busy"}, 64'(busy), 64'(b));
    endtask

    initial begin
        // mv madd mdata | av aadd adata | hold || ar mr | we add data busy
        vt.push_back(v(0,0,0,      1,3,'h55,  0, 1,1, 0,0,0,       1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 1,3,'h55,    1));
        vt.push_back(v(1,5,'h20,   1,4,'h10,  0, 0,1, 0,3,'h55,    1));
        vt.push_back(v(0,0,0,      1,4,'h10,  0, 1,1, 1,5,'h20,    1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 1,4,'h10,    1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 0,4,'h10,    0));
        vt.push_back(v(0,0,0,      1,31,'hFF, 0, 1,1, 0,4,'h10,    0));
        vt.push_back(v(1,31,'hEE,  0,0,0,     0, 0,1, 0,4,'h10,    0));
        vt.push_back(v(0,0,0,      1,8,'h81,  1, 1,1, 0,4,'h10,    1));
        vt.push_back(v(1,9,'h92,   0,0,0,     1, 0,1, 0,4,'h10,    1));
        vt.push_back(v(0,0,0,      1,10,'hA3, 1, 1,1, 0,4,'h10,    1));
        vt.push_back(v(1,11,'hB4,  0,0,0,     1, 0,1, 0,4,'h10,    1));
        vt.push_back(v(0,0,0,      1,12,'hC5, 1, 0,0, 0,4,'h10,    1));
        vt.push_back(v(1,13,'hD0,  0,0,0,     1, 0,0, 0,4,'h10,    1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 0,0, 1,8,'h81,    1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 1,9,'h92,    1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 1,10,'hA3,   1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 1,11,'hB4,   1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 0,11,'hB4,   0));
        vt.push_back(v(0,0,0,      1,14,'hD6, 0, 1,1, 0,11,'hB4,   1));
        vt.push_back(v(0,0,0,      0,0,0,     1, 1,1, 0,11,'hB4,   1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 1,14,'hD6,   1));
        vt.push_back(v(0,0,0,      0,0,0,     1, 1,1, 0,14,'hD6,   0));
        vt.push_back(v(0,0,0,      1,15,'h01, 0, 1,1, 0,14,'hD6,   1));
        vt.push_back(v(0,0,0,      1,16,'h02, 0, 1,1, 1,15,'h01,   1));
        vt.push_back(v(1,17,'h03,  0,0,0,     0, 0,1, 1,16,'h02,   1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 1,17,'h03,   1));
        vt.push_back(v(0,0,0,      0,0,0,     0, 1,1, 0,17,'h03,   0));

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_out("reset", 0, 0, 0, 0);
        check("reset.alu_ready", 64'(alu_ready), 64'd1);
        check("reset.mem_ready", 64'(mem_ready), 64'd1);
`ifdef WB_BYPASS_EN
        check("reset.fwd_hit1", 64'(fwd_hit1), 64'd0);
`endif

        foreach (vt[i]) begin
            mem_valid = vt[i].mv; mem_add = vt[i].madd; mem_data = vt[i].mdata;
            alu_valid = vt[i].av; alu_add = vt[i].aadd; alu_data = vt[i].adata;
            hold = vt[i].hold;
            #1;
            check($sformatf("v%0d.alu_ready", i), 64'(alu_ready), 64'(vt[i].e_ar));
            check($sformatf("v%0d.mem_ready", i), 64'(mem_ready), 64'(vt[i].e_mr));
            tick();
            check_out($sformatf("v%0d", i), vt[i].e_we, vt[i].e_add, vt[i].e_data, vt[i].e_busy);
        end
        idle();
        hold = 1'b0;

`ifdef WB_BYPASS_EN
        hold = 1'b1;
        alu_valid = 1'b1; alu_add = 7; alu_data = 64'h1;
        tick();
        alu_data = 64'h2;
        tick();
        idle();
        fwd_add1 = 7; fwd_add2 = 31;
        #1;
        check("byp.q.hit1", 64'(fwd_hit1), 64'd1);
        check("byp.q.data1", fwd_data1, 64'h2);
        check("byp.xzr.hit2", 64'(fwd_hit2), 64'd0);
        fwd_add2 = 17;
        #1;
        check("byp.stale_out.hit2", 64'(fwd_hit2), 64'd0);
        hold = 1'b0;
        tick();
        check("byp.mix.hit1", 64'(fwd_hit1), 64'd1);
        check("byp.mix.data1", fwd_data1, 64'h2);
        tick();
        check("byp.out.hit1", 64'(fwd_hit1), 64'd1);
        check("byp.out.data1", fwd_data1, 64'h2);
        check_out("byp.out", 1, 7, 64'h2, 1);
        tick();
        check("byp.done.hit1", 64'(fwd_hit1), 64'd0);
`endif

        hold = 1'b1;
        alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_add = 5'(20 + i); alu_data = 64'(i + 1);
            tick();
        end
        idle();
        check("rst.pre.busy", 64'(busy), 64'd1);
        hold = 1'b0;
        reset = 1'b1;
        tick();
        check_out("rst.mid", 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check("rst.mid.alu_ready", 64'(alu_ready), 64'd1);
        check("rst.mid.mem_ready", 64'(mem_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("rst.after%0d", i), 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
